// File: rtl/flyhigh_pkg.sv
// Shared types and constants for the flyhigh game blocks: the coordinate type,
// the hit-detector state enum and the display size.
package flyhigh_pkg;

  localparam int D_WIDTH  = 640;
  localparam int D_HEIGHT = 480;

  typedef logic [11:0] coord_t;

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_HIT    = 2'd1,
    ST_INVULN = 2'd2,
    ST_DEAD   = 2'd3
  } hit_state_e;

  function automatic logic on_screen(input coord_t x, input coord_t y);
    return (x < coord_t'(D_WIDTH)) && (y < coord_t'(D_HEIGHT));
  endfunction

endpackage

// File: rtl/rect_overlap.sv
// Combinational strict-overlap test of two axis-aligned rectangles.
// Edges that only touch do not count as overlap.
module rect_overlap
  import flyhigh_pkg::*;
(
  input  coord_t i_ax1,
  input  coord_t i_ax2,
  input  coord_t i_ay1,
  input  coord_t i_ay2,
  input  coord_t i_bx1,
  input  coord_t i_bx2,
  input  coord_t i_by1,
  input  coord_t i_by2,
  input  logic   i_valid,
  output logic   o_overlap
);

  assign o_overlap = i_valid
                   & (i_ax1 < i_bx2) & (i_ax2 > i_bx1)
                   & (i_ay1 < i_by2) & (i_ay2 > i_by1);

endmodule

// File: rtl/hit_detector.sv
// Target hit detector: lives, post-hit invulnerability and game-over tracking.
// Define HIT_DETECTOR_BLINK_EN to blink o_visible while invulnerable.
//
// state     | meaning
// ST_ALIVE  | target vulnerable, overlap on a frame tick costs a life
// ST_HIT    | single clock, o_hit / o_bullet_clr asserted
// ST_INVULN | counting down frame ticks, overlap ignored
// ST_DEAD   | no lives left, absorbing until reset
module hit_detector
  import flyhigh_pkg::*;
#(
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ani_stb,
  input  logic       i_animate,
  input  logic       i_paused,
  input  logic       i_firing,
  input  coord_t     i_bx1,
  input  coord_t     i_bx2,
  input  coord_t     i_by1,
  input  coord_t     i_by2,
  input  coord_t     i_x1,
  input  coord_t     i_x2,
  input  coord_t     i_y1,
  input  coord_t     i_y2,
  output logic       o_hit,
  output logic       o_bullet_clr,
  output logic [3:0] o_lives,
  output logic       o_visible,
  output logic       o_game_over
);

  if (LIVES < 1 || LIVES > 15) begin : g_bad_lives
    $error("hit_detector: LIVES must be 1..15");
  end
  if (INVULN_FRAMES < 1 || INVULN_FRAMES > 255) begin : g_bad_invuln
    $error("hit_detector: INVULN_FRAMES must be 1..255");
  end
  if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_blink
    $error("hit_detector: BLINK_FRAMES must be 1..255");
  end

  localparam logic [3:0] LIVES_INIT  = 4'(LIVES);
  localparam logic [7:0] INVULN_LOAD = 8'(INVULN_FRAMES);

  hit_state_e state_q, state_d;
  logic [3:0] lives_q, lives_d;
  logic [7:0] inv_cnt_q, inv_cnt_d;
  logic       hit_q, hit_d;
  logic       visible_q, visible_d;
  logic       game_over_q, game_over_d;
`ifdef HIT_DETECTOR_BLINK_EN
  localparam logic [7:0] BLINK_LOAD = 8'(BLINK_FRAMES);
  logic [7:0] blink_cnt_q, blink_cnt_d;
`endif

  logic tick;
  logic overlap;

  assign tick = i_ani_stb & i_animate & ~i_paused;

  rect_overlap u_overlap (
    .i_ax1    (i_bx1),
    .i_ax2    (i_bx2),
    .i_ay1    (i_by1),
    .i_ay2    (i_by2),
    .i_bx1    (i_x1),
    .i_bx2    (i_x2),
    .i_by1    (i_y1),
    .i_by2    (i_y2),
    .i_valid  (i_firing),
    .o_overlap(overlap)
  );

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    inv_cnt_d   = inv_cnt_q;
    hit_d       = 1'b0;
    visible_d   = visible_q;
    game_over_d = game_over_q;
`ifdef HIT_DETECTOR_BLINK_EN
    blink_cnt_d = blink_cnt_q;
`endif
    case (state_q)
      ST_ALIVE: begin
        if (tick && overlap && (lives_q != 4'd0)) begin
          state_d = ST_HIT;
          lives_d = lives_q - 4'd1;
          hit_d   = 1'b1;
        end
      end
      ST_HIT: begin
        if (lives_q == 4'd0) begin
          state_d     = ST_DEAD;
          game_over_d = 1'b1;
          visible_d   = 1'b0;
        end else begin
          state_d   = ST_INVULN;
          inv_cnt_d = INVULN_LOAD;
`ifdef HIT_DETECTOR_BLINK_EN
          visible_d   = 1'b0;
          blink_cnt_d = BLINK_LOAD;
`endif
        end
      end
      ST_INVULN: begin
        if (tick) begin
          inv_cnt_d = inv_cnt_q - 8'd1;
`ifdef HIT_DETECTOR_BLINK_EN
          if (blink_cnt_q <= 8'd1) begin
            visible_d   = ~visible_q;
            blink_cnt_d = BLINK_LOAD;
          end else begin
            blink_cnt_d = blink_cnt_q - 8'd1;
          end
`endif
          // Expiry tick returns to ALIVE but does not itself test overlap.
          if (inv_cnt_q <= 8'd1) begin
            state_d   = ST_ALIVE;
            inv_cnt_d = 8'd0;
`ifdef HIT_DETECTOR_BLINK_EN
            visible_d   = 1'b1;
            blink_cnt_d = 8'd0;
`endif
          end
        end
      end
      ST_DEAD: begin
        game_over_d = 1'b1;
        visible_d   = 1'b0;
      end
      default: state_d = ST_ALIVE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_ALIVE;
      lives_q     <= LIVES_INIT;
      inv_cnt_q   <= 8'd0;
      hit_q       <= 1'b0;
      visible_q   <= 1'b1;
      game_over_q <= 1'b0;
`ifdef HIT_DETECTOR_BLINK_EN
      blink_cnt_q <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      inv_cnt_q   <= inv_cnt_d;
      hit_q       <= hit_d;
      visible_q   <= visible_d;
      game_over_q <= game_over_d;
`ifdef HIT_DETECTOR_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
`endif
    end
  end

  assign o_hit        = hit_q;
  assign o_bullet_clr = hit_q;
  assign o_lives      = lives_q;
  assign o_visible    = visible_q;
  assign o_game_over  = game_over_q;

endmodule
